alu_iter_exec: RTL

- Parametrised execute-stage ALU with a built-in funct/ALUOp decoder. It replaces the separate ALU-control-plus-combinational-ALU pair.
- Single-cycle ops (add, sub, and, or) return a registered result after 1 cycle.
- mul runs as an iterative shift-add multiplier over WIDTH cycles. A valid/ready handshake lets the pipeline stall on ready_o.

---
 rtl/alu_iter_exec.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/alu_iter_exec.sv
// alu_iter_exec: execute-stage ALU with integrated funct/ALUOp decode.
//   add/sub/and/or complete in one cycle; mul is an iterative shift-add
//   taking WIDTH+1 cycles from accept to valid_o, stalling via ready_o.
// Ports:
//   clk_i, rst_i (sync, active-high)     clock / reset
//   valid_i, ready_o                     request handshake
//   alu_op_i, funct_i                    op select (alu_op_i=1 forces add)
//   src1_i, src2_i                       operands
//   flush_i                              abort in-flight mul, drop request
//   valid_o, result_o, zero_o, ovf_o     registered result, held when idle
// Optional: define ALU_ITER_SLT_EN to decode funct 101010 as signed SLT.
module alu_iter_exec #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             alu_op_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             ovf_o
);

  typedef enum logic {S_IDLE, S_MUL} state_t;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_SLT} op_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  state_t           state_q, state_d;
  op_t              op_dec;
  logic             accept;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
  logic [WIDTH-1:0] result_q;
  logic             valid_q, ovf_q;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf;

  always_comb begin
    op_dec = OP_ADD;
    if (!alu_op_i) begin
      case (funct_i)
        6'b100000: op_dec = OP_ADD;
        6'b100010: op_dec = OP_SUB;
        6'b011000: op_dec = OP_MUL;
        6'b100100: op_dec = OP_AND;
        6'b100101: op_dec = OP_OR;
`ifdef ALU_ITER_SLT_EN
        6'b101010: op_dec = OP_SLT;
`else
        6'b101010: op_dec = OP_ADD;
`endif
        default:   op_dec = OP_ADD;
      endcase
    end
  end

  always_comb begin
    sum     = src1_i + src2_i;
    diff    = src1_i - src2_i;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_dec)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) &&
                  (sum[WIDTH-1] != src1_i[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) &&
                  (diff[WIDTH-1] != src1_i[WIDTH-1]);
      end
      OP_AND: alu_res = src1_i & src2_i;
      OP_OR:  alu_res = src1_i | src2_i;
`ifdef ALU_ITER_SLT_EN
      OP_SLT: alu_res[0] = $signed(src1_i) < $signed(src2_i);
`endif
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ready_o = (state_q == S_IDLE);
    accept  = valid_i && ready_o && !flush_i;
    case (state_q)
      S_IDLE: if (accept && op_dec == OP_MUL) state_d = S_MUL;
      S_MUL:  if (flush_i || cnt_q == CNT_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= 1'b0;
      if (state_q == S_IDLE) begin
        if (accept) begin
          if (op_dec == OP_MUL) begin
            mcand_q  <= src1_i;
            mplier_q <= src2_i;
            acc_q    <= '0;
            cnt_q    <= '0;
          end else begin
            result_q <= alu_res;
            ovf_q    <= alu_ovf;
            valid_q  <= 1'b1;
          end
        end
      end else begin
        if (flush_i) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          // extra cycle after the last iteration publishes the product
          result_q <= acc_q;
          ovf_q    <= 1'b0;
          valid_q  <= 1'b1;
          cnt_q    <= '0;
        end else begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign ovf_o    = ovf_q;
  assign zero_o   = (result_q == '0);

endmodule
